// File: rtl/idex_pkg.sv
// ID/EX stage shared types: the payload bundle carried from decode to execute.
// Default operand widths and writeback-select encodings live here as well.
package idex_pkg;

  localparam int P_XLEN = 32;
  localparam int P_VLEN = 48;
  localparam int P_RAW  = 5;
  localparam int P_ALUW = 5;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  typedef struct packed {
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic [P_ALUW-1:0] alu_ctrl;
    logic [P_XLEN-1:0] pc;
    logic [P_XLEN-1:0] rd1;
    logic [P_XLEN-1:0] rd2;
    logic [P_XLEN-1:0] imm;
    logic [P_RAW-1:0]  rd;
    logic [P_RAW-1:0]  vd;
    logic [P_VLEN-1:0] rd1v;
    logic [P_VLEN-1:0] rd2v;
    logic [P_XLEN-1:0] br_target;
  } idex_payload_t;

  localparam idex_payload_t IDEX_PAYLOAD_RST = '0;

endpackage

// File: rtl/idex_if.sv
// Decode-side and execute-side handshake bus of the ID/EX stage.
// slave is the stage itself; master is whoever drives decode and execute.
interface idex_if
  import idex_pkg::*;
#(
  parameter int XLEN = P_XLEN,
  parameter int VLEN = P_VLEN,
  parameter int RAW  = P_RAW,
  parameter int ALUW = P_ALUW
) ();

  logic            in_valid;
  logic            in_ready;
  logic            in_mem_write;
  logic            in_alu_src;
  logic            in_reg_write;
  logic [1:0]      in_mem_to_reg;
  logic [ALUW-1:0] in_alu_ctrl;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rd1;
  logic [XLEN-1:0] in_rd2;
  logic [XLEN-1:0] in_imm;
  logic [RAW-1:0]  in_rd;
  logic [RAW-1:0]  in_vd;
  logic [VLEN-1:0] in_rd1v;
  logic [VLEN-1:0] in_rd2v;

  logic            out_valid;
  logic            out_ready;
  logic            out_mem_write;
  logic            out_alu_src;
  logic            out_reg_write;
  logic [1:0]      out_mem_to_reg;
  logic [ALUW-1:0] out_alu_ctrl;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rd1;
  logic [XLEN-1:0] out_rd2;
  logic [XLEN-1:0] out_imm;
  logic [RAW-1:0]  out_rd;
  logic [RAW-1:0]  out_vd;
  logic [VLEN-1:0] out_rd1v;
  logic [VLEN-1:0] out_rd2v;
  logic [XLEN-1:0] out_br_target;

  modport slave (
    input  in_valid, in_mem_write, in_alu_src, in_reg_write,
    input  in_mem_to_reg, in_alu_ctrl, in_pc, in_rd1, in_rd2,
    input  in_imm, in_rd, in_vd, in_rd1v, in_rd2v,
    input  out_ready,
    output in_ready,
    output out_valid, out_mem_write, out_alu_src, out_reg_write,
    output out_mem_to_reg, out_alu_ctrl, out_pc, out_rd1, out_rd2,
    output out_imm, out_rd, out_vd, out_rd1v, out_rd2v, out_br_target
  );

  modport master (
    output in_valid, in_mem_write, in_alu_src, in_reg_write,
    output in_mem_to_reg, in_alu_ctrl, in_pc, in_rd1, in_rd2,
    output in_imm, in_rd, in_vd, in_rd1v, in_rd2v,
    output out_ready,
    input  in_ready,
    input  out_valid, out_mem_write, out_alu_src, out_reg_write,
    input  out_mem_to_reg, out_alu_ctrl, out_pc, out_rd1, out_rd2,
    input  out_imm, out_rd, out_vd, out_rd1v, out_rd2v, out_br_target
  );

endinterface

// File: rtl/idex_skid_buf.sv
// Generic two-entry skid buffer: main entry drives the output, skid entry
// absorbs one extra beat so the upstream ready is a pure flop output.
module idex_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_FULL  = 2'b10;
  localparam logic [1:0] S_SKID  = 2'b11;

  logic         r_main_v;
  logic         r_skid_v;
  logic [W-1:0] r_main_d;
  logic [W-1:0] r_skid_d;
  logic [1:0]   w_state;
  logic         w_acc;
  logic         w_fire;

  assign w_state = {r_main_v, r_skid_v};
  assign w_acc   = i_valid && !r_skid_v && !flush;
  assign w_fire  = r_main_v && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      unique case (w_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_main_v <= 1'b1;
            r_main_d <= i_data;
          end
        end
        S_FULL: begin
          if (w_fire && w_acc) begin
            r_main_d <= i_data;
          end else if (w_fire) begin
            r_main_v <= 1'b0;
          end else if (w_acc) begin
            r_skid_v <= 1'b1;
            r_skid_d <= i_data;
          end
        end
        S_SKID: begin
          if (w_fire) begin
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
          end
        end
        default: begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_main_v;
  assign o_ready = !r_skid_v;
  assign o_data  = r_main_d;

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: packs decode fields, adds the branch target,
// buffers through a skid pair and gates commit bits on bubbles.
module idex_stage_reg
  import idex_pkg::*;
#(
  parameter int XLEN = P_XLEN,
  parameter int VLEN = P_VLEN,
  parameter int RAW  = P_RAW,
  parameter int ALUW = P_ALUW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  idex_if.slave           bus,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int PW = $bits(idex_payload_t);

  idex_payload_t   w_in;
  idex_payload_t   w_out;
  logic            w_ov;
  logic [CNTW-1:0] r_stall;

  always_comb begin
    w_in            = IDEX_PAYLOAD_RST;
    w_in.mem_write  = bus.in_mem_write;
    w_in.alu_src    = bus.in_alu_src;
    w_in.reg_write  = bus.in_reg_write;
    w_in.mem_to_reg = bus.in_mem_to_reg;
    w_in.alu_ctrl   = bus.in_alu_ctrl;
    w_in.pc         = bus.in_pc;
    w_in.rd1        = bus.in_rd1;
    w_in.rd2        = bus.in_rd2;
    w_in.imm        = bus.in_imm;
    w_in.rd         = bus.in_rd;
    w_in.vd         = bus.in_vd;
    w_in.rd1v       = bus.in_rd1v;
    w_in.rd2v       = bus.in_rd2v;
    // Target rides with the entry so execute never sees a recomputed sum
    w_in.br_target  = bus.in_pc + bus.in_imm;
  end

  idex_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  (w_in),
    .o_valid (w_ov),
    .i_ready (bus.out_ready),
    .o_data  (w_out)
  );

  assign bus.out_valid      = w_ov;
  assign bus.out_mem_write  = w_ov && w_out.mem_write;
  assign bus.out_reg_write  = w_ov && w_out.reg_write;
  assign bus.out_alu_src    = w_out.alu_src;
  assign bus.out_mem_to_reg = w_out.mem_to_reg;
  assign bus.out_alu_ctrl   = ALUW'(w_out.alu_ctrl);
  assign bus.out_pc         = XLEN'(w_out.pc);
  assign bus.out_rd1        = XLEN'(w_out.rd1);
  assign bus.out_rd2        = XLEN'(w_out.rd2);
  assign bus.out_imm        = XLEN'(w_out.imm);
  assign bus.out_rd         = RAW'(w_out.rd);
  assign bus.out_vd         = RAW'(w_out.vd);
  assign bus.out_rd1v       = VLEN'(w_out.rd1v);
  assign bus.out_rd2v       = VLEN'(w_out.rd2v);
  assign bus.out_br_target  = XLEN'(w_out.br_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_ov && !bus.out_ready && (r_stall != {CNTW{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed vector table, reset/saturation
// sequences, then random traffic against a queue-based reference.
module tb_idex_stage_reg;
  import idex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        rst_s = 1'b1;
  logic        flush_s = 1'b0;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  idex_if bus ();
  idex_if bus_s ();

  idex_stage_reg u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  idex_stage_reg #(.CNTW(4)) u_sat (
    .clk       (clk),
    .rst       (rst_s),
    .flush     (flush_s),
    .bus       (bus_s),
    .stall_cnt (stall_s)
  );

  typedef struct {
    logic        rs;
    logic        fl;
    logic        v;
    logic        ordy;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        ov;
    logic        ir;
    logic [31:0] opc;
    logic [31:0] obr;
    logic [15:0] st;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_pl(input string nm, input idex_payload_t act,
                        input idex_payload_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rs, logic fl, logic v, logic ordy,
                              logic [31:0] pc, logic [31:0] imm,
                              logic ov, logic ir, logic [31:0] opc,
                              logic [31:0] obr, logic [15:0] st);
    vec_t t;
    t.rs = rs; t.fl = fl; t.v = v; t.ordy = ordy;
    t.pc = pc; t.imm = imm; t.ov = ov; t.ir = ir;
    t.opc = opc; t.obr = obr; t.st = st;
    return t;
  endfunction

  task automatic drive(input idex_payload_t p, input logic v);
    bus.in_valid      = v;
    bus.in_mem_write  = p.mem_write;
    bus.in_alu_src    = p.alu_src;
    bus.in_reg_write  = p.reg_write;
    bus.in_mem_to_reg = p.mem_to_reg;
    bus.in_alu_ctrl   = p.alu_ctrl;
    bus.in_pc         = p.pc;
    bus.in_rd1        = p.rd1;
    bus.in_rd2        = p.rd2;
    bus.in_imm        = p.imm;
    bus.in_rd         = p.rd;
    bus.in_vd         = p.vd;
    bus.in_rd1v       = p.rd1v;
    bus.in_rd2v       = p.rd2v;
  endtask

  function automatic idex_payload_t get_out();
    idex_payload_t p;
    p.mem_write  = bus.out_mem_write;
    p.alu_src    = bus.out_alu_src;
    p.reg_write  = bus.out_reg_write;
    p.mem_to_reg = bus.out_mem_to_reg;
    p.alu_ctrl   = bus.out_alu_ctrl;
    p.pc         = bus.out_pc;
    p.rd1        = bus.out_rd1;
    p.rd2        = bus.out_rd2;
    p.imm        = bus.out_imm;
    p.rd         = bus.out_rd;
    p.vd         = bus.out_vd;
    p.rd1v       = bus.out_rd1v;
    p.rd2v       = bus.out_rd2v;
    p.br_target  = bus.out_br_target;
    return p;
  endfunction

  function automatic idex_payload_t rand_pl();
    idex_payload_t p;
    p.mem_write  = 1'($urandom);
    p.alu_src    = 1'($urandom);
    p.reg_write  = 1'($urandom);
    p.mem_to_reg = 2'($urandom_range(0, 2));
    p.alu_ctrl   = 5'($urandom);
    p.pc         = $urandom;
    p.rd1        = $urandom;
    p.rd2        = $urandom;
    p.imm        = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255)) : $urandom;
    p.rd         = 5'($urandom);
    p.vd         = 5'($urandom);
    p.rd1v       = {16'($urandom), $urandom};
    p.rd2v       = {16'($urandom), $urandom};
    p.br_target  = $urandom;
    return p;
  endfunction

  initial begin
    idex_payload_t base;
    idex_payload_t q[$];
    idex_payload_t shown;
    idex_payload_t exp;
    idex_payload_t p;
    int            mst;
    logic          v;
    logic          ordy;
    logic          fl;
    logic          acc;
    logic          fire;

    bus_s.in_valid = 1'b0; bus_s.in_mem_write = 1'b0;
    bus_s.in_alu_src = 1'b0; bus_s.in_reg_write = 1'b0;
    bus_s.in_mem_to_reg = '0; bus_s.in_alu_ctrl = '0;
    bus_s.in_pc = '0; bus_s.in_rd1 = '0; bus_s.in_rd2 = '0;
    bus_s.in_imm = '0; bus_s.in_rd = '0; bus_s.in_vd = '0;
    bus_s.in_rd1v = '0; bus_s.in_rd2v = '0; bus_s.out_ready = 1'b0;

    base = IDEX_PAYLOAD_RST;
    base.mem_write  = 1'b1;
    base.reg_write  = 1'b1;
    base.alu_src    = 1'b1;
    base.mem_to_reg = M2R_MEM;
    base.alu_ctrl   = 5'h3;
    base.rd1        = 32'h1111_2222;
    base.rd         = 5'd7;
    base.rd1v       = 48'hABCD_0123_4567;
    drive(base, 1'b0);
    bus.out_ready = 1'b0;

    tbl[0]  = mk(1, 0, 0, 0, 32'h0,         32'h0,  0, 1, 32'h0,         32'h0,   0);
    tbl[1]  = mk(0, 0, 1, 1, 32'h100,       32'h20, 1, 1, 32'h100,       32'h120, 0);
    tbl[2]  = mk(0, 0, 1, 1, 32'h104,       32'h20, 1, 1, 32'h104,       32'h124, 0);
    tbl[3]  = mk(0, 0, 0, 1, 32'h0,         32'h0,  0, 1, 32'h104,       32'h124, 0);
    tbl[4]  = mk(0, 0, 1, 0, 32'h200,       32'h10, 1, 1, 32'h200,       32'h210, 0);
    tbl[5]  = mk(0, 0, 1, 0, 32'h204,       32'h10, 1, 0, 32'h200,       32'h210, 1);
    tbl[6]  = mk(0, 0, 1, 0, 32'h208,       32'h10, 1, 0, 32'h200,       32'h210, 2);
    tbl[7]  = mk(0, 0, 1, 0, 32'h208,       32'h10, 1, 0, 32'h200,       32'h210, 3);
    tbl[8]  = mk(0, 0, 0, 1, 32'h0,         32'h0,  1, 1, 32'h204,       32'h214, 3);
    tbl[9]  = mk(0, 0, 0, 1, 32'h0,         32'h0,  0, 1, 32'h204,       32'h214, 3);
    tbl[10] = mk(0, 0, 1, 0, 32'h300,       32'h0,  1, 1, 32'h300,       32'h300, 3);
    tbl[11] = mk(0, 0, 1, 0, 32'h304,       32'h0,  1, 0, 32'h300,       32'h300, 4);
    tbl[12] = mk(0, 1, 1, 0, 32'h308,       32'h0,  0, 1, 32'h300,       32'h300, 5);
    tbl[13] = mk(0, 0, 0, 1, 32'h0,         32'h0,  0, 1, 32'h300,       32'h300, 5);
    tbl[14] = mk(0, 0, 1, 1, 32'hFFFF_FFF0, 32'h20, 1, 1, 32'hFFFF_FFF0, 32'h10,  5);
    tbl[15] = mk(0, 0, 1, 1, 32'h400,       32'h20, 1, 1, 32'h400,       32'h420, 5);
    tbl[16] = mk(0, 1, 1, 1, 32'h404,       32'h20, 0, 1, 32'h400,       32'h420, 5);

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rs;
      flush = tbl[i].fl;
      bus.out_ready = tbl[i].ordy;
      p = base;
      p.pc = tbl[i].pc;
      p.imm = tbl[i].imm;
      drive(p, tbl[i].v);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].ir));
      chk($sformatf("vec%0d out_pc", i), 64'(bus.out_pc), 64'(tbl[i].opc));
      chk($sformatf("vec%0d br_target", i), 64'(bus.out_br_target), 64'(tbl[i].obr));
      chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].st));
      chk($sformatf("vec%0d reg_write", i), 64'(bus.out_reg_write), 64'(tbl[i].ov));
      chk($sformatf("vec%0d mem_write", i), 64'(bus.out_mem_write), 64'(tbl[i].ov));
    end
    flush = 1'b0;

    // rst mid-stream with both entries held
    bus.out_ready = 1'b0;
    p = base; p.pc = 32'h500; drive(p, 1'b1);
    @(posedge clk); @(negedge clk);
    p = base; p.pc = 32'h504; drive(p, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("skid in_ready", 64'(bus.in_ready), 64'd0);
    chk("skid stall_cnt", 64'(stall_cnt), 64'd6);
    rst = 1'b1;
    #1;
    chk("rst before edge out_valid", 64'(bus.out_valid), 64'd1);
    chk("rst before edge stall_cnt", 64'(stall_cnt), 64'd6);
    @(posedge clk); @(negedge clk);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
    chk_pl("rst payload", get_out(), IDEX_PAYLOAD_RST);
    drive(base, 1'b0);
    @(posedge clk); @(negedge clk);

    // saturation on the 4-bit counter instance
    rst_s = 1'b0;
    bus_s.in_valid = 1'b1;
    bus_s.in_pc = 32'h600;
    @(posedge clk); @(negedge clk);
    bus_s.in_valid = 1'b0;
    chk("sat out_valid", 64'(bus_s.out_valid), 64'd1);
    chk("sat start", 64'(stall_s), 64'd0);
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("sat cyc%0d", i), 64'(stall_s), 64'((i > 15) ? 15 : i));
    end

    // random traffic against the queue model
    rst = 1'b1;
    drive(base, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    q.delete();
    shown = IDEX_PAYLOAD_RST;
    mst = 0;
    for (int c = 0; c < 3000; c++) begin
      exp = shown;
      exp.mem_write = exp.mem_write && (q.size() > 0);
      exp.reg_write = exp.reg_write && (q.size() > 0);
      chk($sformatf("rnd%0d out_valid", c), 64'(bus.out_valid), 64'(q.size() > 0));
      chk($sformatf("rnd%0d in_ready", c), 64'(bus.in_ready), 64'(q.size() < 2));
      chk($sformatf("rnd%0d stall_cnt", c), 64'(stall_cnt), 64'(mst));
      chk_pl($sformatf("rnd%0d payload", c), get_out(), exp);

      v = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 29) == 0);
      p = rand_pl();
      drive(p, v);
      bus.out_ready = ordy;
      flush = fl;

      acc = v && (q.size() < 2) && !fl;
      fire = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && (mst < 65535)) mst++;
      if (fl) begin
        q.delete();
      end else begin
        if (fire) void'(q.pop_front());
        if (acc) begin
          p.br_target = p.pc + p.imm;
          q.push_back(p);
        end
      end
      if (q.size() > 0) shown = q[0];
      @(posedge clk); @(negedge clk);
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
